// File: rtl/unified_mem_arbiter.sv
// Single-port memory arbiter for fetch and load/store with one transaction in flight.
// Data wins ties unless fetch has lost STARVE_MAX times in a row.
module unified_mem_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [3:0] LAT_C    = 4'(MEM_LAT);
    localparam logic [3:0] STARVE_C = 4'(STARVE_MAX);

    state_t            state_q, state_d;
    logic [3:0]        lat_q, lat_d;
    logic [3:0]        starve_q, starve_d;
    logic              owner_dm_q, owner_dm_d;
    logic              we_q, we_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              dm_rvalid_q, dm_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              gnt_if, gnt_dm;

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        owner_dm_d  = owner_dm_q;
        we_d        = we_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rvalid_d = 1'b0;
        dm_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        gnt_if      = 1'b0;
        gnt_dm      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Fetch only overrides data once it has lost STARVE_MAX ties in a row
                gnt_dm = dm_req && !(if_req && (starve_q == STARVE_C));
                gnt_if = if_req && !gnt_dm;
                if (gnt_dm) begin
                    owner_dm_d  = 1'b1;
                    we_d        = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    mem_en_d    = 1'b1;
                    mem_we_d    = dm_we;
                    state_d     = S_ISSUE;
                    if (if_req && (starve_q != STARVE_C)) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (gnt_if) begin
                    owner_dm_d  = 1'b0;
                    we_d        = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_en_d    = 1'b1;
                    state_d     = S_ISSUE;
                    starve_d    = 4'd0;
                end
            end
            S_ISSUE: begin
                lat_d   = LAT_C;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                lat_d = lat_q - 4'd1;
                // Last wait cycle lines up with the memory's read data
                if (lat_q == 4'd1) begin
                    if (owner_dm_q) begin
                        if (!we_q) begin
                            dm_rdata_d = mem_rdata;
                        end
                    end else begin
                        if_rdata_d = mem_rdata;
                    end
                    if_rvalid_d = !owner_dm_q;
                    dm_rvalid_d = owner_dm_q;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            lat_q       <= 4'd0;
            starve_q    <= 4'd0;
            owner_dm_q  <= 1'b0;
            we_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            owner_dm_q  <= owner_dm_d;
            we_q        <= we_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign if_gnt    = gnt_if;
    assign dm_gnt    = gnt_dm;
    assign if_rvalid = if_rvalid_q;
    assign dm_rvalid = dm_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a fixed-latency memory model.
module tb_unified_mem_arbiter;

    localparam int ADDR_W     = 64;
    localparam int DATA_W     = 64;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;
    localparam logic [63:0] JUNK = 64'hBADB_ADBA_DBAD_BADB;

    logic              clk;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    logic [63:0] rd_data;
    logic [15:0] hist;
    logic        exp_if;
    int          n_assert;
    int          n_fail;

    unified_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory returns rd_data only in the cycle exactly MEM_LAT after mem_en
    initial begin
        hist      = '0;
        mem_rdata = JUNK;
        forever begin
            @(negedge clk);
            hist      = {hist[14:0], mem_en};
            mem_rdata = hist[MEM_LAT] ? rd_data : JUNK;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_assert++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        if_req   = 1'b0;
        if_addr  = '0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        rd_data  = '0;

        step();
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_if_rvalid", if_rvalid, 1'b0);
        chk1("rst_dm_rvalid", dm_rvalid, 1'b0);
        chk64("rst_mem_addr", mem_addr, 64'h0);
        reset = 1'b0;
        step();

        // Single fetch
        if_req  = 1'b1;
        if_addr = 64'h100;
        rd_data = 64'h0050_0093;
        #1;
        chk1("t1_if_gnt", if_gnt, 1'b1);
        chk1("t1_dm_gnt", dm_gnt, 1'b0);
        chk1("t1_busy_T", busy, 1'b0);
        step();
        if_req = 1'b0;
        #1;
        chk1("t1_mem_en", mem_en, 1'b1);
        chk64("t1_mem_addr", mem_addr, 64'h100);
        chk1("t1_mem_we", mem_we, 1'b0);
        chk1("t1_busy_T1", busy, 1'b1);
        chk1("t1_no_gnt_busy", if_gnt, 1'b0);
        step();
        #1;
        chk1("t1_mem_en_off", mem_en, 1'b0);
        chk1("t1_busy_T2", busy, 1'b1);
        step();
        #1;
        chk1("t1_busy_T3", busy, 1'b1);
        chk1("t1_rvalid_early", if_rvalid, 1'b0);
        step();
        #1;
        chk1("t1_if_rvalid", if_rvalid, 1'b1);
        chk64("t1_if_rdata", if_rdata, 64'h0050_0093);
        chk1("t1_busy_T4", busy, 1'b1);
        chk1("t1_dm_rvalid", dm_rvalid, 1'b0);
        step();
        #1;
        chk1("t1_rvalid_pulse", if_rvalid, 1'b0);
        chk1("t1_idle", busy, 1'b0);

        // Single store
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 64'h2000;
        dm_wdata = 64'hDEAD_BEEF;
        rd_data  = 64'h1111;
        #1;
        chk1("t2_dm_gnt", dm_gnt, 1'b1);
        chk1("t2_if_gnt", if_gnt, 1'b0);
        step();
        dm_req   = 1'b0;
        dm_addr  = 64'hFFFF;
        dm_wdata = 64'h0;
        #1;
        chk1("t2_mem_en", mem_en, 1'b1);
        chk1("t2_mem_we", mem_we, 1'b1);
        chk64("t2_mem_wdata", mem_wdata, 64'hDEAD_BEEF);
        chk64("t2_mem_addr", mem_addr, 64'h2000);
        step();
        #1;
        chk1("t2_mem_we_off", mem_we, 1'b0);
        step();
        step();
        #1;
        chk1("t2_dm_rvalid", dm_rvalid, 1'b1);
        chk64("t2_dm_rdata_kept", dm_rdata, 64'h0);
        chk64("t2_if_rdata_kept", if_rdata, 64'h0050_0093);
        step();
        #1;
        chk1("t2_rvalid_pulse", dm_rvalid, 1'b0);
        chk1("t2_idle", busy, 1'b0);

        // Both requesters held: D,D,D,D,F repeating, grants 5 cycles apart
        if_req  = 1'b1;
        if_addr = 64'h200;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 64'h3000;
        rd_data = 64'h77;
        for (int g = 0; g < 10; g++) begin
            #1;
            exp_if = (g == 4) || (g == 9);
            chk1("t3_if_gnt", if_gnt, exp_if);
            chk1("t3_dm_gnt", dm_gnt, !exp_if);
            for (int k = 0; k < 5; k++) begin
                step();
                if (k < 4) begin
                    #1;
                    chk1("t3_gap_no_gnt", if_gnt | dm_gnt, 1'b0);
                end
            end
        end
        chk64("t3_if_rdata", if_rdata, 64'h77);
        chk64("t3_dm_rdata", dm_rdata, 64'h77);

        // Tie with counter cleared: data first, held fetch on next IDLE
        #1;
        chk1("t4_dm_gnt", dm_gnt, 1'b1);
        chk1("t4_if_gnt", if_gnt, 1'b0);
        step();
        dm_req = 1'b0;
        for (int k = 0; k < 4; k++) step();
        #1;
        chk1("t4_if_gnt_next", if_gnt, 1'b1);
        chk1("t4_dm_gnt_next", dm_gnt, 1'b0);
        step();
        if_req = 1'b0;
        for (int k = 0; k < 4; k++) step();
        #1;
        chk1("t4_idle", busy, 1'b0);

        // Reset during WAIT of a load
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 64'h40;
        rd_data = 64'hCAFE;
        #1;
        chk1("t5_dm_gnt", dm_gnt, 1'b1);
        step();
        dm_req = 1'b0;
        step();
        chk64("t5_pre_mem_addr", mem_addr, 64'h40);
        chk1("t5_pre_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk1("t5_rst_busy", busy, 1'b0);
        chk1("t5_rst_mem_en", mem_en, 1'b0);
        chk64("t5_rst_mem_addr", mem_addr, 64'h0);
        chk64("t5_rst_if_rdata", if_rdata, 64'h0);
        chk64("t5_rst_dm_rdata", dm_rdata, 64'h0);
        step();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk1("t5_no_dm_rvalid", dm_rvalid, 1'b0);
            chk1("t5_no_busy", busy, 1'b0);
            step();
        end
        dm_req  = 1'b1;
        dm_addr = 64'h80;
        rd_data = 64'h1234_5678_9ABC_DEF0;
        #1;
        chk1("t5_fresh_gnt", dm_gnt, 1'b1);
        step();
        dm_req = 1'b0;
        #1;
        chk1("t5_fresh_mem_en", mem_en, 1'b1);
        chk64("t5_fresh_mem_addr", mem_addr, 64'h80);
        step();
        step();
        step();
        #1;
        chk1("t5_fresh_rvalid", dm_rvalid, 1'b1);
        chk64("t5_fresh_rdata", dm_rdata, 64'h1234_5678_9ABC_DEF0);
        step();

        // Data request pulsed while busy is never served
        if_req  = 1'b1;
        if_addr = 64'h300;
        rd_data = 64'hABC;
        #1;
        chk1("t6_if_gnt", if_gnt, 1'b1);
        step();
        if_req  = 1'b0;
        dm_req  = 1'b1;
        dm_addr = 64'h500;
        #1;
        chk1("t6_dm_gnt_busy", dm_gnt, 1'b0);
        chk64("t6_mem_addr", mem_addr, 64'h300);
        step();
        dm_req = 1'b0;
        for (int k = 0; k < 7; k++) begin
            #1;
            chk1("t6_no_mem_en", mem_en, 1'b0);
            chk1("t6_no_dm_gnt", dm_gnt, 1'b0);
            chk1("t6_no_dm_rvalid", dm_rvalid, 1'b0);
            step();
        end
        chk64("t6_if_rdata", if_rdata, 64'hABC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
